clock_switch_sequencer: RTL and testbench



---
 rtl/clock_switch_sequencer.sv | 117 +++++++++++
 tb/tb_clock_switch_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_sequencer.sv
// Sequences one-hot clock-select changes: gate the datapath, drain, swap, settle, re-enable.
// Optional macro CLOCK_SEQ_ABORT_EN lets abort cancel a change while draining.
module clock_switch_sequencer #(
    parameter int CLOCK_WIDTH   = 6,
    parameter int DRAIN_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [CLOCK_WIDTH-1:0] req_sel,
    output logic                   req_ready,
    input  logic                   en_req,
    input  logic                   abort,
    output logic [CLOCK_WIDTH-1:0] clock_sel,
    output logic                   switch,
    output logic                   busy,
    output logic                   done_irq,
    output logic                   err_irq
);
    localparam int MAXC = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CLOCK_WIDTH-1:0] SEL_ONE = CLOCK_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP, SETTLE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CLOCK_WIDTH-1:0] pend_q, pend_d;
    logic [CLOCK_WIDTH-1:0] sel_q, sel_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   one_hot;

`ifndef CLOCK_SEQ_ABORT_EN
    logic abort_unused;
    assign abort_unused = abort;
`endif

    assign one_hot = (req_sel != '0) && ((req_sel & (req_sel - SEL_ONE)) == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!one_hot) begin
                        err_d = 1'b1;
                    end else if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = req_sel;
                        cnt_d   = CW'(DRAIN_CYCLES - 1);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
`ifdef CLOCK_SEQ_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                    pend_d  = '0;
                    err_d   = 1'b1;
                end else
`endif
                if (cnt_q == '0) state_d = SWAP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            SWAP: begin
                sel_d   = pend_q;
                cnt_d   = CW'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    pend_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            sel_q   <= SEL_ONE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Enable follows en_req only while idle; it never depends on req_valid.
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign switch    = en_req && (state_q == IDLE) && !reset;
    assign clock_sel = sel_q;
    assign done_irq  = done_q;
    assign err_irq   = err_q;
endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Directed bench for clock_switch_sequencer with an event-level model checked every cycle.
module tb_clock_switch_sequencer;
    localparam int W = 6, D = 4, S = 8;
`ifdef CLOCK_SEQ_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic         clk = 1'b0, reset = 1'b1, req_valid = 1'b0, en_req = 1'b1, abort = 1'b0;
    logic [W-1:0] req_sel = '0;
    logic [W-1:0] clock_sel;
    logic         req_ready, switch, busy, done_irq, err_irq;

    always #5 clk = ~clk;

    clock_switch_sequencer #(.CLOCK_WIDTH(W), .DRAIN_CYCLES(D), .SETTLE_CYCLES(S)) dut (
        .wb_clk_i(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .en_req(en_req), .abort(abort), .clock_sel(clock_sel),
        .switch(switch), .busy(busy), .done_irq(done_irq), .err_irq(err_irq)
    );

    int n_cmp = 0, n_bad = 0;

    // Model: a change is a window of edges relative to its accept edge.
    int           cyc = 0, m_start = 0;
    bit           m_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [W-1:0] m_sel = 6'b000001, m_new = '0;

    always @(posedge clk) begin
        cyc++;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_sel  = 6'b000001;
        end else if (m_busy) begin
            if (ABORT_ON && abort && cyc <= m_start + D) begin
                m_busy = 1'b0;
                e_err  = 1'b1;
            end else begin
                if (cyc == m_start + D + 1) m_sel = m_new;
                if (cyc == m_start + D + S + 1) begin
                    m_busy = 1'b0;
                    e_done = 1'b1;
                end
            end
        end else if (req_valid) begin
            if ($countones(req_sel) != 1) e_err = 1'b1;
            else if (req_sel == m_sel)    e_done = 1'b1;
            else begin
                m_busy  = 1'b1;
                m_start = cyc;
                m_new   = req_sel;
            end
        end
    end

    always @(negedge clk) begin
        logic [W+4:0] exp_v, act_v;
        if (cyc > 0) begin
            exp_v = {m_sel, m_busy, !m_busy, en_req && !m_busy && !reset, e_done, e_err};
            act_v = {clock_sel, busy, req_ready, switch, done_irq, err_irq};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle%0d {sel,busy,rdy,sw,done,err}: got %b want %b", cyc, act_v, exp_v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step(); look();
        chk("reset_sel", int'(clock_sel), 1);
        chk("reset_switch", int'(switch), 1);
        chk("reset_ready", int'(req_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_irq", int'({done_irq, err_irq}), 0);

        // Real change to 000100
        req_valid = 1'b1; req_sel = 6'b000100;
        step(); req_valid = 1'b0; look();
        chk("chg_busy", int'(busy), 1);
        chk("chg_switch", int'(switch), 0);
        repeat (4) step(); look();
        chk("chg_sel_e4", int'(clock_sel), 1);
        step(); look();
        chk("chg_sel_e5", int'(clock_sel), 6'b000100);
        repeat (7) step(); look();
        chk("chg_busy_e12", int'(busy), 1);
        chk("chg_done_e12", int'(done_irq), 0);
        step(); look();
        chk("chg_done_e13", int'(done_irq), 1);
        chk("chg_busy_e13", int'(busy), 0);
        chk("chg_switch_e13", int'(switch), 1);
        step(); look();
        chk("chg_done_e14", int'(done_irq), 0);

        // Bad, duplicate and zero requests
        en_req = 1'b0; req_valid = 1'b1; req_sel = 6'b000110;
        step(); req_valid = 1'b0; look();
        chk("bad_err", int'(err_irq), 1);
        chk("bad_busy", int'(busy), 0);
        chk("bad_sel", int'(clock_sel), 6'b000100);
        en_req = 1'b1; req_valid = 1'b1; req_sel = 6'b000100;
        step(); req_valid = 1'b0; look();
        chk("dup_done", int'(done_irq), 1);
        chk("dup_busy", int'(busy), 0);
        req_valid = 1'b1; req_sel = 6'b000000;
        step(); req_valid = 1'b0; look();
        chk("zero_err", int'(err_irq), 1);

        // Second request held during a change
        req_valid = 1'b1; req_sel = 6'b000001;
        step(); req_valid = 1'b0;
        step(); step();
        en_req = 1'b0; req_valid = 1'b1; req_sel = 6'b010000;
        repeat (11) step(); look();
        chk("hold_done", int'(done_irq), 1);
        chk("hold_ready", int'(req_ready), 1);
        chk("hold_sel", int'(clock_sel), 6'b000001);
        en_req = 1'b1;
        step(); req_valid = 1'b0; look();
        chk("hold_accepted", int'(busy), 1);
        repeat (13) step(); look();
        chk("hold_final_sel", int'(clock_sel), 6'b010000);
        chk("hold_final_done", int'(done_irq), 1);

        // Reset during SETTLE
        req_valid = 1'b1; req_sel = 6'b000010;
        step(); req_valid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step(); look();
        chk("rst_sel", int'(clock_sel), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done_irq), 0);
        reset = 1'b0;
        repeat (10) step(); look();
        chk("rst_after_done", int'(done_irq), 0);

        // Abort while draining
        req_valid = 1'b1; req_sel = 6'b000100;
        step(); req_valid = 1'b0;
        repeat (2) step();
        abort = 1'b1;
        step(); abort = 1'b0; look();
`ifdef CLOCK_SEQ_ABORT_EN
        chk("abort_busy", int'(busy), 0);
        chk("abort_err", int'(err_irq), 1);
        chk("abort_sel", int'(clock_sel), 1);
`else
        chk("noabort_busy", int'(busy), 1);
        chk("noabort_err", int'(err_irq), 0);
`endif
        repeat (12) step(); look();
`ifdef CLOCK_SEQ_ABORT_EN
        chk("abort_final_sel", int'(clock_sel), 1);
`else
        chk("noabort_final_sel", int'(clock_sel), 6'b000100);
`endif
        chk("abort_final_busy", int'(busy), 0);

        // Abort during SETTLE is ignored in every build
        req_valid = 1'b1; req_sel = 6'b001000;
        step(); req_valid = 1'b0;
        repeat (6) step();
        abort = 1'b1;
        step(); abort = 1'b0;
        repeat (10) step(); look();
        chk("settle_abort_sel", int'(clock_sel), 6'b001000);
        chk("settle_abort_busy", int'(busy), 0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
